mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-port, variable-latency memory between instruction fetch and
//   the data stage (memRead/memWrite from the control decoder). Fixed data priority
//   with a starvation guard for fetch, a req/ack handshake to memory, per-requester
//   done pulses, a pipeline stall output and a watchdog timeout.
// PARAMETERS
//   ADDR_W      32  address width
//   DATA_W      32  data width
//   MAX_STREAK  4   consecutive data grants allowed while if_req pending (>=1)
//   TIMEOUT     64  cycles in BUSY without mem_ack before abort; 0 disables
// PORTS
//   clk          in   1       system clock, rising edge
//   rst          in   1       asynchronous, active-high reset
//   if_req       in   1       fetch request; held until if_done
//   if_addr      in   ADDR_W  fetch address
//   if_rdata     out  DATA_W  fetched word, valid while if_done=1, held after
//   if_done      out  1       1-cycle pulse, fetch complete
//   d_read       in   1       data load request (memRead); held until d_done
//   d_write      in   1       data store request (memWrite); held until d_done
//   d_addr       in   ADDR_W  data address
//   d_wdata      in   DATA_W  store data
//   d_rdata      out  DATA_W  load data, valid while d_done=1, held after
//   d_done       out  1       1-cycle pulse, data access complete
//   mem_req      out  1       memory request, held until mem_ack
//   mem_we       out  1       1=write, 0=read; stable while mem_req
//   mem_addr     out  ADDR_W  latched address; stable while mem_req
//   mem_wdata    out  DATA_W  latched write data; stable while mem_req
//   mem_rdata    in   DATA_W  read data, valid in mem_ack cycle
//   mem_ack      in   1       access complete (may be high in first mem_req cycle)
//   stall        out  1       pipeline hold
//   timeout_err  out  1       sticky: some access was aborted by watchdog
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0 (rdata regs 0, mem_* 0, done 0, timeout_err 0);
//     streak and watchdog counters 0. Reset mid-transaction aborts it, no done pulse.
//   FSM IDLE -> BUSY_D | BUSY_I -> DONE -> IDLE. All outputs except stall registered.
//   IDLE arbitration (sampled at edge):
//     - data pending (d_read|d_write) and NOT (if_req and streak==MAX_STREAK) -> BUSY_D,
//       streak+1 if if_req else streak=0.
//     - else if_req -> BUSY_I, streak=0.
//     - d_read&d_write both high: treated as write; d_rdata unchanged.
//   Entering BUSY_x: mem_req=1, mem_we/addr/wdata latched from winner. Watchdog=0.
//   BUSY_x: each cycle mem_ack=0 -> watchdog+1. mem_ack=1 -> mem_req=0, capture
//     mem_rdata into x_rdata (reads only), go DONE with x_done=1 for one cycle.
//   Timeout: watchdog reaches TIMEOUT-1 with no ack -> mem_req=0, x_rdata=0,
//     x_done pulses, timeout_err=1 (sticky until rst). Late mem_ack in IDLE/DONE ignored.
//   DONE: one dead cycle; no new grant; -> IDLE. Min latency: request sampled cycle N,
//     mem_req cycle N+1, ack N+1, done N+2, next grant sampled N+3.
//   Requester dropping req while BUSY: access still completes and done still pulses.
//   stall (combinational) = ((d_read|d_write) & ~d_done) | (if_req & ~if_done).
// TESTING
//   Single load, mem_ack same cycle as mem_req, mem_rdata=32'h1234_5678 -> d_done at
//     N+2, d_rdata=32'h1234_5678, mem_we=0, stall low cycle after done.
//   Store d_addr=0x100 d_wdata=0xCAFE with 3-cycle ack delay -> mem_we=1, addr/wdata
//     stable 4 cycles of mem_req, d_done once, d_rdata unchanged.
//   if_req and d_read both constant high, ack=1 immediate -> grant order D,D,D,D,I
//     repeating (MAX_STREAK=4); no requester waits more than 5 grants.
//   No mem_ack, TIMEOUT=64 -> mem_req drops after 64 cycles, done pulse, rdata=0,
//     timeout_err=1 and stays 1; ack arriving afterwards produces no extra done.
//   rst asserted asynchronously mid BUSY_D -> mem_req, done, timeout_err 0 at once
//     (no clock edge); after release fresh fetch completes normally.
//   d_read&d_write both high -> single write access, mem_we=1, one d_done.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory between fetch and data, data-first with fetch starvation guard
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              timeout_err
);
  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, DONE} state_t;
  localparam int SW = $clog2(MAX_STREAK + 1);
  state_t state;
  logic [SW-1:0] streak;
  logic [31:0] wd;
  logic dp, hit, expire;
  assign dp = d_read | d_write;
  assign hit = if_req && streak == SW'(MAX_STREAK);
  assign expire = TIMEOUT != 0 && wd == 32'(TIMEOUT - 1);
  assign stall = (dp & ~d_done) | (if_req & ~if_done);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      streak <= '0;
      wd <= '0;
      if_rdata <= '0;
      if_done <= 1'b0;
      d_rdata <= '0;
      d_done <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      timeout_err <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE:
          if (dp && !hit) begin
            state <= BUSY_D;
            streak <= if_req ? streak + 1'b1 : '0;
            mem_req <= 1'b1;
            mem_we <= d_write;
            mem_addr <= d_addr;
            mem_wdata <= d_wdata;
            wd <= '0;
          end else if (if_req) begin
            state <= BUSY_I;
            streak <= '0;
            mem_req <= 1'b1;
            mem_we <= 1'b0;
            mem_addr <= if_addr;
            mem_wdata <= '0;
            wd <= '0;
          end
        BUSY_D, BUSY_I:
          if (mem_ack || expire) begin
            state <= DONE;
            mem_req <= 1'b0;
            if (!mem_ack) timeout_err <= 1'b1;
            if (state == BUSY_D) begin
              d_done <= 1'b1;
              if (!mem_ack) d_rdata <= '0;
              else if (!mem_we) d_rdata <= mem_rdata;
            end else begin
              if_done <= 1'b1;
              if_rdata <= mem_ack ? mem_rdata : '0;
            end
          end else wd <= wd + 32'd1;
        default: state <= IDLE;
      endcase
    end
endmodule
